// File: rtl/etapa_id_pkg.sv
// Shared constants, defaults and instruction field decode for the ID stage.
package etapa_id_pkg;

    localparam int unsigned OPCODE_W     = 4;
    localparam int unsigned ADDR_W       = 3;
    localparam int unsigned INSTR_W      = 14;

    // Field bit positions inside the 14-bit instruction word
    localparam int unsigned OPCODE_LSB   = 10;
    localparam int unsigned DEST_LSB     = 6;
    localparam int unsigned DEST_ALT_LSB = 8;
    localparam int unsigned DEST_ALT_W   = 2;
    localparam int unsigned VEC1_LSB     = 3;
    localparam int unsigned VEC2_LSB     = 0;
    localparam int unsigned SCA1_LSB     = 0;
    localparam int unsigned IMM_LSB      = 0;
    localparam int unsigned IMM_W        = 8;
    localparam int unsigned SHIFT_LSB    = 3;
    localparam int unsigned SHIFT_W      = 8;

    // Default parameter values
    localparam int unsigned LANES_DEF    = 4;
    localparam int unsigned ELEM_W_DEF   = 8;
    localparam int unsigned NVREG_DEF    = 8;
    localparam int unsigned NSREG_DEF    = 8;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [ADDR_W-1:0]   dest;
        logic [ADDR_W-1:0]   vec1;
        logic [ADDR_W-1:0]   vec2;
        logic [ADDR_W-1:0]   sca1;
        logic [IMM_W-1:0]    imm;
        logic [SHIFT_W-1:0]  shift;
    } campos_t;

    // Splits an instruction word into its operand/destination fields
    function automatic campos_t decodificar(input logic [INSTR_W-1:0] instr,
                                            input logic               sel_dest);
        campos_t c;
        c.opcode = instr[OPCODE_LSB +: OPCODE_W];
        c.dest   = sel_dest ? {1'b0, instr[DEST_ALT_LSB +: DEST_ALT_W]}
                            : instr[DEST_LSB +: ADDR_W];
        c.vec1   = instr[VEC1_LSB +: ADDR_W];
        c.vec2   = instr[VEC2_LSB +: ADDR_W];
        c.sca1   = instr[SCA1_LSB +: ADDR_W];
        c.imm    = instr[IMM_LSB +: IMM_W];
        c.shift  = SHIFT_W'(instr[SHIFT_LSB +: ADDR_W]);
        return c;
    endfunction

endpackage

// File: rtl/etapa_id_pipe_banco_registros.sv
// Register bank: one write port, two bypassed read ports, flat dump of the low entries.
module banco_registros
    import etapa_id_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned NDUMP  = DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       wa,
    input  logic [DATA_W-1:0]       wd,
    input  logic [ADDR_W-1:0]       ra1,
    input  logic [ADDR_W-1:0]       ra2,
    output logic [DATA_W-1:0]       rd1_c,
    output logic [DATA_W-1:0]       rd2_c,
    output logic [NDUMP*DATA_W-1:0] dump_c
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage: synchronous clear, single write port
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                mem[i] <= '0;
            end else if (we && (wa == ADDR_W'(i))) begin
                mem[i] <= wd;
            end
        end
    end

    // Reads see the write of the same cycle (write-through)
    always_comb begin
        rd1_c = '0;
        rd2_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ra1 == ADDR_W'(i)) rd1_c = mem[i];
            if (ra2 == ADDR_W'(i)) rd2_c = mem[i];
        end
        if (we && (wa == ra1)) rd1_c = wd;
        if (we && (wa == ra2)) rd2_c = wd;
    end

    // Low entries exported side by side, entry 0 in the LSBs
    always_comb begin
        dump_c = '0;
        for (int i = 0; i < NDUMP; i++) begin
            dump_c[i*DATA_W +: DATA_W] = mem[i];
        end
    end

endmodule

// File: rtl/etapa_id_pipe.sv
// Instruction-decode stage: field decode, busy-bit scoreboard, operand fetch, output register.
module etapa_id_pipe
    import etapa_id_pkg::*;
#(
    parameter int unsigned LANES  = LANES_DEF,
    parameter int unsigned ELEM_W = ELEM_W_DEF,
    parameter int unsigned NVREG  = NVREG_DEF,
    parameter int unsigned NSREG  = NSREG_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INSTR_W-1:0]        instruccion,
    input  logic                      sel_dest,
    input  logic                      reg_rdv,
    input  logic                      reg_rds,
    input  logic                      dst_wrv,
    input  logic                      dst_wrs,
    input  logic                      wb_wrv,
    input  logic                      wb_wrs,
    input  logic [ADDR_W-1:0]         wb_dir,
    input  logic [LANES*ELEM_W-1:0]   wb_datav,
    input  logic [ELEM_W-1:0]         wb_datas,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OPCODE_W-1:0]       opcode,
    output logic [ADDR_W-1:0]         dir_dest_out,
    output logic [IMM_W-1:0]          inmediato,
    output logic [SHIFT_W-1:0]        shift,
    output logic [LANES*ELEM_W-1:0]   data_vec1,
    output logic [LANES*ELEM_W-1:0]   data_vec2,
    output logic [ELEM_W-1:0]         data_sca1,
    output logic                      out_wrv,
    output logic                      out_wrs,
    output logic [LANES*ELEM_W-1:0]   VFS
);

    localparam int unsigned VEC_W = LANES * ELEM_W;

    campos_t            f_c;
    logic [VEC_W-1:0]   v_rd1_c;
    logic [VEC_W-1:0]   v_rd2_c;
    logic [ELEM_W-1:0]  s_rd1_c;
    logic [ELEM_W-1:0]  unused_s_rd2;
    logic [VEC_W-1:0]   unused_v_dump;
    logic [NVREG-1:0]   busy_v, clr_v_c, set_v_c;
    logic [NSREG-1:0]   busy_s, clr_s_c, set_s_c;
    logic               hazard_c;
    logic               accept_c;

    assign f_c = decodificar(instruccion, sel_dest);

    banco_registros #(.DATA_W(VEC_W), .DEPTH(NVREG), .NDUMP(1)) u_banco_v (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_wrv),
        .wa     (wb_dir),
        .wd     (wb_datav),
        .ra1    (f_c.vec1),
        .ra2    (f_c.vec2),
        .rd1_c  (v_rd1_c),
        .rd2_c  (v_rd2_c),
        .dump_c (unused_v_dump)
    );

    banco_registros #(.DATA_W(ELEM_W), .DEPTH(NSREG), .NDUMP(LANES)) u_banco_s (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_wrs),
        .wa     (wb_dir),
        .wd     (wb_datas),
        .ra1    (f_c.sca1),
        .ra2    ('0),
        .rd1_c  (s_rd1_c),
        .rd2_c  (unused_s_rd2),
        .dump_c (VFS)
    );

    // Hazard check against busy bits, ignoring those freed by this cycle's write-back
    always_comb begin
        clr_v_c  = '0;
        clr_s_c  = '0;
        hazard_c = 1'b0;
        for (int i = 0; i < NVREG; i++) begin
            clr_v_c[i] = wb_wrv && (wb_dir == ADDR_W'(i));
            if (busy_v[i] && !clr_v_c[i]) begin
                if (reg_rdv && ((f_c.vec1 == ADDR_W'(i)) || (f_c.vec2 == ADDR_W'(i)))) hazard_c = 1'b1;
                if (dst_wrv && (f_c.dest == ADDR_W'(i))) hazard_c = 1'b1;
            end
        end
        for (int i = 0; i < NSREG; i++) begin
            clr_s_c[i] = wb_wrs && (wb_dir == ADDR_W'(i));
            if (busy_s[i] && !clr_s_c[i]) begin
                if (reg_rds && (f_c.sca1 == ADDR_W'(i))) hazard_c = 1'b1;
                if (dst_wrs && (f_c.dest == ADDR_W'(i))) hazard_c = 1'b1;
            end
        end
    end

    assign in_ready = (!out_valid || out_ready) && !hazard_c;
    assign accept_c = in_valid && in_ready;

    // Destinations reserved by the instruction being accepted
    always_comb begin
        set_v_c = '0;
        set_s_c = '0;
        for (int i = 0; i < NVREG; i++) begin
            set_v_c[i] = accept_c && dst_wrv && (f_c.dest == ADDR_W'(i));
        end
        for (int i = 0; i < NSREG; i++) begin
            set_s_c[i] = accept_c && dst_wrs && (f_c.dest == ADDR_W'(i));
        end
    end

    // Busy scoreboard; a set beats a clear of the same bit
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_v <= '0;
            busy_s <= '0;
        end else begin
            busy_v <= (busy_v & ~clr_v_c) | set_v_c;
            busy_s <= (busy_s & ~clr_s_c) | set_s_c;
        end
    end

    // Output bundle: load on accept, hold while stalled, drop valid once consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            opcode       <= '0;
            dir_dest_out <= '0;
            inmediato    <= '0;
            shift        <= '0;
            data_vec1    <= '0;
            data_vec2    <= '0;
            data_sca1    <= '0;
            out_wrv      <= 1'b0;
            out_wrs      <= 1'b0;
        end else if (accept_c) begin
            out_valid    <= 1'b1;
            opcode       <= f_c.opcode;
            dir_dest_out <= f_c.dest;
            inmediato    <= f_c.imm;
            shift        <= f_c.shift;
            data_vec1    <= reg_rdv ? v_rd1_c : '0;
            data_vec2    <= reg_rdv ? v_rd2_c : '0;
            data_sca1    <= reg_rds ? s_rd1_c : '0;
            out_wrv      <= dst_wrv;
            out_wrs      <= dst_wrs;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_etapa_id_pipe.sv
// Bench for etapa_id_pipe: directed scenarios then random traffic against an array-based model.
module tb_etapa_id_pipe;

    localparam int LANES = 4;
    localparam int EW    = 8;
    localparam int VW    = LANES * EW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [13:0]   instruccion;
    logic          sel_dest, reg_rdv, reg_rds, dst_wrv, dst_wrs;
    logic          wb_wrv, wb_wrs;
    logic [2:0]    wb_dir;
    logic [VW-1:0] wb_datav;
    logic [EW-1:0] wb_datas;
    logic          out_valid, out_ready;
    logic [3:0]    opcode;
    logic [2:0]    dir_dest_out;
    logic [7:0]    inmediato, shift;
    logic [VW-1:0] data_vec1, data_vec2, VFS;
    logic [EW-1:0] data_sca1;
    logic          out_wrv, out_wrs;

    etapa_id_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruccion(instruccion), .sel_dest(sel_dest), .reg_rdv(reg_rdv),
        .reg_rds(reg_rds), .dst_wrv(dst_wrv), .dst_wrs(dst_wrs),
        .wb_wrv(wb_wrv), .wb_wrs(wb_wrs), .wb_dir(wb_dir),
        .wb_datav(wb_datav), .wb_datas(wb_datas), .out_valid(out_valid),
        .out_ready(out_ready), .opcode(opcode), .dir_dest_out(dir_dest_out),
        .inmediato(inmediato), .shift(shift), .data_vec1(data_vec1),
        .data_vec2(data_vec2), .data_sca1(data_sca1), .out_wrv(out_wrv),
        .out_wrs(out_wrs), .VFS(VFS)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [VW-1:0] m_vreg [8];
    logic [EW-1:0] m_sreg [8];
    bit            m_bv [8];
    bit            m_bs [8];
    bit            m_out_valid, m_wrv, m_wrs;
    logic [3:0]    m_opcode;
    logic [2:0]    m_dest;
    logic [7:0]    m_imm, m_shift;
    logic [VW-1:0] m_dv1, m_dv2;
    logic [EW-1:0] m_ds1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int dest_of();
        return sel_dest ? int'(instruccion[9:8]) : int'(instruccion[8:6]);
    endfunction

    // Busy as seen by the hazard check: a write-back this cycle frees the register
    function automatic bit bv_eff(input int r);
        return m_bv[r] && !(wb_wrv && int'(wb_dir) == r);
    endfunction

    function automatic bit bs_eff(input int r);
        return m_bs[r] && !(wb_wrs && int'(wb_dir) == r);
    endfunction

    function automatic bit model_ready();
        int  v1 = int'(instruccion[5:3]);
        int  v2 = int'(instruccion[2:0]);
        int  d  = dest_of();
        bit  hz;
        hz = (reg_rdv && (bv_eff(v1) || bv_eff(v2))) || (reg_rds && bs_eff(v2)) ||
             (dst_wrv && bv_eff(d)) || (dst_wrs && bs_eff(d));
        return (!m_out_valid || out_ready) && !hz;
    endfunction

    function automatic logic [VW-1:0] vread(input int r);
        return (wb_wrv && int'(wb_dir) == r) ? wb_datav : m_vreg[r];
    endfunction

    function automatic logic [EW-1:0] sread(input int r);
        return (wb_wrs && int'(wb_dir) == r) ? wb_datas : m_sreg[r];
    endfunction

    function automatic logic [VW-1:0] exp_vfs();
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*EW +: EW] = m_sreg[i];
        return v;
    endfunction

    task automatic model_edge(input bit acc);
        int d = dest_of();
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_vreg[i] = '0; m_sreg[i] = '0; m_bv[i] = 0; m_bs[i] = 0;
            end
            m_out_valid = 0; m_wrv = 0; m_wrs = 0; m_opcode = '0; m_dest = '0;
            m_imm = '0; m_shift = '0; m_dv1 = '0; m_dv2 = '0; m_ds1 = '0;
        end else begin
            if (acc) begin
                m_out_valid = 1;
                m_opcode    = instruccion[13:10];
                m_dest      = 3'(d);
                m_imm       = instruccion[7:0];
                m_shift     = {5'b0, instruccion[5:3]};
                m_dv1       = reg_rdv ? vread(int'(instruccion[5:3])) : '0;
                m_dv2       = reg_rdv ? vread(int'(instruccion[2:0])) : '0;
                m_ds1       = reg_rds ? sread(int'(instruccion[2:0])) : '0;
                m_wrv       = dst_wrv;
                m_wrs       = dst_wrs;
            end else if (out_ready) begin
                m_out_valid = 0;
            end
            if (wb_wrv) begin m_vreg[wb_dir] = wb_datav; m_bv[wb_dir] = 0; end
            if (wb_wrs) begin m_sreg[wb_dir] = wb_datas; m_bs[wb_dir] = 0; end
            if (acc && dst_wrv) m_bv[d] = 1;
            if (acc && dst_wrs) m_bs[d] = 1;
        end
    endtask

    // One clock: check in_ready mid-cycle, advance model at the edge, check outputs after it
    task automatic cycle();
        bit er, acc;
        @(negedge clk);
        er  = model_ready();
        check("in_ready", in_ready, er);
        acc = in_valid && er;
        @(posedge clk);
        model_edge(acc);
        #1;
        check("out_valid", out_valid, m_out_valid);
        check("VFS", VFS, exp_vfs());
        if (m_out_valid) begin
            check("opcode", opcode, m_opcode);
            check("dir_dest_out", dir_dest_out, m_dest);
            check("inmediato", inmediato, m_imm);
            check("shift", shift, m_shift);
            check("data_vec1", data_vec1, m_dv1);
            check("data_vec2", data_vec2, m_dv2);
            check("data_sca1", data_sca1, m_ds1);
            check("out_wrv", out_wrv, m_wrv);
            check("out_wrs", out_wrs, m_wrs);
        end
    endtask

    task automatic idle();
        rst = 0; in_valid = 0; instruccion = '0; sel_dest = 0;
        reg_rdv = 0; reg_rds = 0; dst_wrv = 0; dst_wrs = 0;
        wb_wrv = 0; wb_wrs = 0; wb_dir = '0; wb_datav = '0; wb_datas = '0;
        out_ready = 1;
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_edge(0);
        rst = 0;

        // Reset state: everything cleared, no register busy
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_VFS", VFS, '0);
        check("rst_data_vec1", data_vec1, '0);
        for (int r = 0; r < 8; r++) begin
            instruccion = 14'((r << 6) | (r << 3) | r);
            reg_rdv = 1; reg_rds = 1; dst_wrv = 1; dst_wrs = 1;
            cycle();
            check("rst_busy_clear", in_ready, 1'b1);
        end

        // Scalar write-back shows on VFS the next cycle
        idle();
        wb_wrs = 1; wb_dir = 3'd2; wb_datas = 8'h5A;
        cycle();
        wb_wrs = 0;
        check("vfs_s2", VFS[23:16], 8'h5A);

        // RAW stall on v3 until its write-back, which is bypassed into the operand
        idle();
        in_valid = 1; dst_wrv = 1; instruccion = 14'h00C0;
        cycle();
        dst_wrv = 0; reg_rdv = 1; instruccion = 14'h0018;
        cycle();
        check("raw_stall1", in_ready, 1'b0);
        cycle();
        check("raw_stall2", in_ready, 1'b0);
        wb_wrv = 1; wb_dir = 3'd3; wb_datav = 32'h11223344;
        #1;
        check("raw_release", in_ready, 1'b1);
        cycle();
        check("raw_fwd_vec1", data_vec1, 32'h11223344);
        check("raw_accepted", out_valid, 1'b1);

        // Field decode with the alternate destination field
        idle();
        in_valid = 1; sel_dest = 1; instruccion = 14'h0300;
        cycle();
        check("dest_alt", dir_dest_out, 3'b011);
        instruccion = 14'h2C2D;
        cycle();
        check("dec_opcode", opcode, 4'hB);
        check("dec_imm", inmediato, 8'h2D);
        check("dec_shift", shift, 8'h05);

        // Downstream stall holds the bundle, then back-to-back accepts
        out_ready = 0; instruccion = 14'h1234;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_opcode", opcode, 4'hB);
            check("stall_in_ready", in_ready, 1'b0);
        end
        out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            instruccion = 14'(((k + 1) << 10) | k);
            cycle();
            check("b2b_opcode", opcode, 4'(k + 1));
            check("b2b_valid", out_valid, 1'b1);
        end

        // Reset with a bundle in flight and v1 busy
        idle();
        in_valid = 1; dst_wrv = 1; instruccion = 14'h0040;
        cycle();
        in_valid = 0; dst_wrv = 0; out_ready = 0;
        cycle();
        check("pre_rst_valid", out_valid, 1'b1);
        rst = 1; in_valid = 1; reg_rdv = 1; instruccion = 14'h0008;
        cycle();
        rst = 0;
        check("rst_flush_valid", out_valid, 1'b0);
        out_ready = 1;
        #1;
        check("rst_v1_free", in_ready, 1'b1);
        cycle();
        check("rst_v1_accept", out_valid, 1'b1);
        check("rst_v1_data", data_vec1, '0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst         = ($urandom_range(0, 59) == 0);
            in_valid    = ($urandom_range(0, 3) != 0);
            instruccion = 14'($urandom);
            sel_dest    = 1'($urandom);
            reg_rdv     = 1'($urandom);
            reg_rds     = 1'($urandom);
            dst_wrv     = ($urandom_range(0, 2) == 0);
            dst_wrs     = ($urandom_range(0, 2) == 0);
            wb_wrv      = ($urandom_range(0, 2) == 0);
            wb_wrs      = ($urandom_range(0, 2) == 0);
            wb_dir      = 3'($urandom);
            wb_datav    = VW'($urandom);
            wb_datas    = EW'($urandom);
            out_ready   = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
